// File: rtl/regfile_wb_arbiter.sv
// Writeback front-end for the integer register file: two buffered producers,
// round-robin merged into one registered write per cycle, plus RAW pending lookup.
module regfile_wb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              src0_valid,
  output logic              src0_ready,
  input  logic [ADDR_W-1:0] src0_rd,
  input  logic [DATA_W-1:0] src0_data,
  input  logic              src1_valid,
  output logic              src1_ready,
  input  logic [ADDR_W-1:0] src1_rd,
  input  logic [DATA_W-1:0] src1_data,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              rf_we,
  input  logic [ADDR_W-1:0] chk_addr_1,
  input  logic [ADDR_W-1:0] chk_addr_2,
  output logic              chk_pend_1,
  output logic              chk_pend_2,
  output logic              idle
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [1:0]             in_valid, in_ready, push, pop, not_empty, hit1, hit2;
  logic [1:0][ADDR_W-1:0] in_rd, head_rd;
  logic [1:0][DATA_W-1:0] in_data, head_data;

  logic              rr_q, rr_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic              rf_we_q, rf_we_d;

  assign in_valid = {src1_valid, src0_valid};
  assign in_rd    = {src1_rd, src0_rd};
  assign in_data  = {src1_data, src0_data};

  for (genvar s = 0; s < 2; s++) begin : g_fifo
    logic [ADDR_W-1:0] mem_rd_q   [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     cnt_q;
    logic [DEPTH-1:0]  occ;
    logic              h1, h2;

    // Ready depends only on occupancy, so a full FIFO refuses even while draining.
    assign not_empty[s] = (cnt_q != '0);
    assign in_ready[s]  = (cnt_q != FULL_CNT) && !RST;
    assign push[s]      = in_valid[s] && in_ready[s];
    assign head_rd[s]   = mem_rd_q[rptr_q];
    assign head_data[s] = mem_data_q[rptr_q];
    assign hit1[s]      = h1;
    assign hit2[s]      = h2;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push[s]) wptr_q <= wptr_q + PW'(1);
        if (pop[s])  rptr_q <= rptr_q + PW'(1);
        cnt_q <= cnt_q + CW'(push[s]) - CW'(pop[s]);
      end
    end

    always_ff @(posedge CLK) begin
      if (push[s]) begin
        mem_rd_q[wptr_q]   <= in_rd[s];
        mem_data_q[wptr_q] <= in_data[s];
      end
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
      occ = '0;
      h1  = 1'b0;
      h2  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        occ[i] = ({1'b0, PW'(i) - rptr_q} < cnt_q);
        if (occ[i] && (mem_rd_q[i] == chk_addr_1)) h1 = 1'b1;
        if (occ[i] && (mem_rd_q[i] == chk_addr_2)) h2 = 1'b1;
      end
    end
  end

  always_comb begin
    rr_d      = rr_q;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    pop       = not_empty;
    if (not_empty == 2'b11) begin
      pop  = rr_q ? 2'b10 : 2'b01;
      rr_d = ~rr_q;
    end
    if (pop[1]) begin
      rf_addr_d = head_rd[1];
      rf_data_d = head_data[1];
    end else if (pop[0]) begin
      rf_addr_d = head_rd[0];
      rf_data_d = head_data[0];
    end else begin
      rf_addr_d = rf_addr_q;
      rf_data_d = rf_data_q;
    end
    rf_we_d = (|pop) && (rf_addr_d != '0);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_q      <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      rf_we_q   <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      rf_we_q   <= rf_we_d;
    end
  end

  assign src0_ready = in_ready[0];
  assign src1_ready = in_ready[1];
  assign rf_addr    = rf_addr_q;
  assign rf_data    = rf_data_q;
  assign rf_we      = rf_we_q;
  assign chk_pend_1 = (chk_addr_1 != '0) && ((|hit1) || (rf_we_q && (rf_addr_q == chk_addr_1)));
  assign chk_pend_2 = (chk_addr_2 != '0) && ((|hit2) || (rf_we_q && (rf_addr_q == chk_addr_2)));
  assign idle       = (not_empty == 2'b00) && !rf_we_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter; a queue-level model
// predicts every register-file write, which a negedge monitor scores.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        src0_valid, src1_valid, src0_ready, src1_ready;
  logic [4:0]  src0_rd, src1_rd, rf_addr, chk_addr_1, chk_addr_2;
  logic [31:0] src0_data, src1_data, rf_data;
  logic        rf_we, chk_pend_1, chk_pend_2, idle;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .src0_valid(src0_valid), .src0_ready(src0_ready), .src0_rd(src0_rd), .src0_data(src0_data),
    .src1_valid(src1_valid), .src1_ready(src1_ready), .src1_rd(src1_rd), .src1_data(src1_data),
    .rf_addr(rf_addr), .rf_data(rf_data), .rf_we(rf_we),
    .chk_addr_1(chk_addr_1), .chk_addr_2(chk_addr_2),
    .chk_pend_1(chk_pend_1), .chk_pend_2(chk_pend_2), .idle(idle)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [4:0] rd; logic [31:0] data; } req_t;

  req_t       q0[$], q1[$], expq[$];
  logic [4:0] obs[$];
  logic       out_we_m, rr_m;
  logic [4:0] out_addr_m;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic pend_m(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (q0[i]) if (q0[i].rd == a) return 1'b1;
    foreach (q1[i]) if (q1[i].rd == a) return 1'b1;
    return out_we_m && (out_addr_m == a);
  endfunction

  // Reference model: per-source queues, one dequeue per edge by round robin.
  initial begin
    req_t e;
    int   w;
    logic r0, r1;
    forever begin
      @(posedge CLK or posedge RST);
      if (RST) begin
        q0.delete(); q1.delete(); expq.delete();
        out_we_m = 1'b0; out_addr_m = 5'd0; rr_m = 1'b0;
      end else begin
        r0 = (q0.size() < DEPTH);
        r1 = (q1.size() < DEPTH);
        w  = -1;
        if (q0.size() > 0 && q1.size() > 0) begin
          w = rr_m ? 1 : 0;
          rr_m = !rr_m;
        end else if (q0.size() > 0) w = 0;
        else if (q1.size() > 0) w = 1;
        if (w >= 0) begin
          e = (w == 0) ? q0.pop_front() : q1.pop_front();
          out_we_m   = (e.rd != 5'd0);
          out_addr_m = e.rd;
          if (e.rd != 5'd0) expq.push_back(e);
        end else begin
          out_we_m = 1'b0;
        end
        if (src0_valid && r0) q0.push_back('{src0_rd, src0_data});
        if (src1_valid && r1) q1.push_back('{src1_rd, src1_data});
      end
    end
  end

  // Monitor: scores each presented write and the status outputs every cycle.
  initial begin
    req_t e;
    forever begin
      @(negedge CLK);
      if (RST) begin
        check("rst_ready0", src0_ready, 1'b0);
        check("rst_ready1", src1_ready, 1'b0);
        check("rst_we", rf_we, 1'b0);
        check("rst_idle", idle, 1'b1);
        check("rst_pend", {chk_pend_1, chk_pend_2}, 2'b00);
      end else begin
        check("ready0", src0_ready, q0.size() < DEPTH);
        check("ready1", src1_ready, q1.size() < DEPTH);
        if (rf_we) begin
          obs.push_back(rf_addr);
          if (expq.size() == 0) begin
            check("unexpected_write", rf_addr, 5'd0);
            check("unexpected_we", rf_we, 1'b0);
          end else begin
            e = expq.pop_front();
            check("wr_addr", rf_addr, e.rd);
            check("wr_data", rf_data, e.data);
          end
        end else if (expq.size() != 0) begin
          e = expq.pop_front();
          check("missing_write", rf_we, 1'b1);
        end
        check("pend1", chk_pend_1, pend_m(chk_addr_1));
        check("pend2", chk_pend_2, pend_m(chk_addr_2));
        check("idle", idle, (q0.size() == 0) && (q1.size() == 0) && !out_we_m);
      end
    end
  end

  task automatic stream(input int n0, input int n1, input logic [4:0] b0, input logic [4:0] b1,
                        input int budget);
    int   i0 = 0, i1 = 0, cyc = 0;
    logic a0, a1;
    while ((i0 < n0 || i1 < n1) && cyc < budget) begin
      src0_valid = (i0 < n0); src0_rd = 5'(b0 + 5'(i0)); src0_data = $urandom;
      src1_valid = (i1 < n1); src1_rd = 5'(b1 + 5'(i1)); src1_data = $urandom;
      chk_addr_1 = 5'($urandom_range(0, 15));
      chk_addr_2 = src0_rd;
      @(negedge CLK);
      a0 = src0_valid && src0_ready;
      a1 = src1_valid && src1_ready;
      @(posedge CLK); #1;
      if (a0) i0++;
      if (a1) i1++;
      cyc++;
    end
    check("stream_done", (i0 >= n0) && (i1 >= n1), 1'b1);
    src0_valid = 1'b0; src1_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  initial begin
    logic [4:0] order [8];
    order = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14};
    RST = 1'b1;
    src0_valid = 1'b1; src1_valid = 1'b1;
    src0_rd = 5'd7; src1_rd = 5'd8; src0_data = 32'h0; src1_data = 32'h0;
    chk_addr_1 = 5'd7; chk_addr_2 = 5'd8;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0; src0_valid = 1'b0; src1_valid = 1'b0;
    #1;
    check("ready0_after_rst", src0_ready, 1'b1);
    check("ready1_after_rst", src1_ready, 1'b1);
    idle_cycles(2);

    // Single write to x5.
    chk_addr_1 = 5'd5; chk_addr_2 = 5'd0;
    src0_valid = 1'b1; src0_rd = 5'd5; src0_data = 32'hDEADBEEF;
    @(posedge CLK); #1;
    src0_valid = 1'b0;
    check("single_pend_after_accept", chk_pend_1, 1'b1);
    @(posedge CLK); #1;
    check("single_we", rf_we, 1'b1);
    check("single_addr", rf_addr, 5'd5);
    check("single_data", rf_data, 32'hDEADBEEF);
    @(posedge CLK); #1;
    check("single_we_drop", rf_we, 1'b0);
    check("single_pend_drop", chk_pend_1, 1'b0);
    idle_cycles(2);

    // x0 writes are consumed without a register-file write.
    chk_addr_1 = 5'd0;
    src1_valid = 1'b1; src1_rd = 5'd0; src1_data = 32'h1234;
    @(posedge CLK); #1;
    src1_valid = 1'b0;
    check("x0_not_idle", idle, 1'b0);
    idle_cycles(3);
    check("x0_idle_back", idle, 1'b1);

    // Contention ordering.
    obs.delete();
    stream(4, 4, 5'd1, 5'd11, 100);
    idle_cycles(8);
    check("contention_count", obs.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < obs.size()) check("contention_order", obs[i], order[i]);

    // Backpressure with wrap: src0 overfilled while src1 keeps contending.
    stream(DEPTH + 10, 30, 5'd1, 5'd16, 500);
    idle_cycles(8);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      src0_valid = $urandom_range(0, 1) == 1; src0_rd = 5'($urandom_range(0, 7)); src0_data = $urandom;
      src1_valid = $urandom_range(0, 2) != 0; src1_rd = 5'($urandom_range(0, 7)); src1_data = $urandom;
      chk_addr_1 = 5'($urandom_range(0, 7)); chk_addr_2 = 5'($urandom_range(0, 7));
      @(posedge CLK); #1;
    end
    src0_valid = 1'b0; src1_valid = 1'b0;
    idle_cycles(8);

    // Reset mid-stream with two entries queued and a write on the output.
    src0_valid = 1'b1; src0_rd = 5'd21; src0_data = 32'hA1;
    src1_valid = 1'b1; src1_rd = 5'd22; src1_data = 32'hA2;
    @(posedge CLK); #1;
    src1_valid = 1'b0; src0_rd = 5'd23; src0_data = 32'hA3;
    @(posedge CLK); #1;
    src0_valid = 1'b0;
    check("mid_we_before", rf_we, 1'b1);
    check("mid_queued", q0.size() + q1.size(), 2);
    RST = 1'b1;
    #1;
    check("mid_we_dropped", rf_we, 1'b0);
    check("mid_idle", idle, 1'b1);
    idle_cycles(2);
    RST = 1'b0;
    obs.delete();
    idle_cycles(10);
    check("mid_no_stale", obs.size(), 0);
    check("final_exp_empty", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
